quad_decoder: RTL and testbench

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_decoder.sv | 93 +++++++++
 tb/tb_quad_decoder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// quad_decoder: synchronised quadrature decoder with up/down position counter,
// sticky illegal-transition flag and a post-reset settling phase.
module quad_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             phase_a,
    input  logic             phase_b,
    output logic             step,
    output logic             dir,
    output logic [WIDTH-1:0] position,
    output logic             error
);
    typedef enum logic {INIT, RUN} state_t;

    state_t                 state, state_nx;
    logic [2:0]             cnt, cnt_nx;
    logic [SYNC_STAGES-1:0] sync_a, sync_b;
    logic [1:0]             prev_ab, cur_ab;
    logic [3:0]             tr;
    logic                   up, down, bad, run;
    logic                   up_q, down_q, bad_q;

    assign cur_ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
    assign tr     = {prev_ab, cur_ab};
    assign up     = (tr == 4'b0010) || (tr == 4'b1011) || (tr == 4'b1101) || (tr == 4'b0100);
    assign down   = (tr == 4'b0001) || (tr == 4'b0111) || (tr == 4'b1110) || (tr == 4'b1000);
    assign bad    = &(prev_ab ^ cur_ab);
    assign run    = (state == RUN);

    // INIT lets the synchronisers and prev_ab settle before any decode is trusted
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == INIT) begin
            cnt_nx = cnt + 3'd1;
            if (cnt == 3'(SYNC_STAGES)) begin
                state_nx = RUN;
                cnt_nx   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a   <= '0;
            sync_b   <= '0;
            prev_ab  <= '0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            bad_q    <= 1'b0;
            step     <= 1'b0;
            dir      <= 1'b1;
            position <= '0;
            error    <= 1'b0;
        end else begin
            sync_a   <= {sync_a[SYNC_STAGES-2:0], phase_a};
            sync_b   <= {sync_b[SYNC_STAGES-2:0], phase_b};
            prev_ab  <= cur_ab;
            up_q     <= run && enable && up;
            down_q   <= run && enable && down;
            bad_q    <= run && bad;
            step     <= up_q || down_q;
            if (up_q || down_q)
                dir <= up_q;
            // clear wins over a coincident step; the pulse itself still goes out
            if (clear)
                position <= '0;
            else if (up_q)
                position <= position + WIDTH'(1);
            else if (down_q)
                position <= position - WIDTH'(1);
            if (clear)
                error <= 1'b0;
            else if (bad_q)
                error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: table-driven scoreboard bench for quad_decoder.
module tb_quad_decoder;
    localparam int S = 2;

    logic       clk = 1'b0, reset = 1'b0, enable = 1'b1, clear = 1'b0;
    logic       phase_a = 1'b0, phase_b = 1'b0;
    logic       step, dir, error;
    logic [3:0] position;
    int         total = 0, bad = 0;

    typedef struct {
        logic [1:0] ab;
        logic       en;
        logic       clr;
        logic       stp;
        logic       dr;
        logic [3:0] pos;
        logic       err;
    } vec_t;

    vec_t       vecs[$];
    vec_t       sb[$];
    logic [1:0] upseq [4];

    quad_decoder #(.WIDTH(4), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .phase_a(phase_a), .phase_b(phase_b),
        .step(step), .dir(dir), .position(position), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", n, a, e);
        end
    endtask

    task automatic outs(input string n, input vec_t e);
        chk({n, ".step"}, 32'(step), 32'(e.stp));
        chk({n, ".dir"}, 32'(dir), 32'(e.dr));
        chk({n, ".pos"}, 32'(position), 32'(e.pos));
        chk({n, ".err"}, 32'(error), 32'(e.err));
    endtask

    function automatic void add(input logic [1:0] ab, input logic en, input logic clr,
                                input logic stp, input logic dr, input logic [3:0] pos,
                                input logic err);
        vec_t v;
        v.ab = ab; v.en = en; v.clr = clr; v.stp = stp; v.dr = dr; v.pos = pos; v.err = err;
        vecs.push_back(v);
    endfunction

    task automatic apply(input string n, input vec_t v);
        vec_t e;
        @(negedge clk);
        sb.push_back(v);
        if (v.clr) begin
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            e = sb.pop_front();
            outs(n, e);
        end else begin
            phase_a = v.ab[1];
            phase_b = v.ab[0];
            enable  = v.en;
            repeat (S + 1) @(posedge clk);
            #1;
            if (v.stp) chk({n, ".early"}, 32'(step), 0);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            outs(n, e);
            @(posedge clk);
            #1;
            chk({n, ".pulse"}, 32'(step), 0);
        end
    endtask

    initial begin
        vec_t rv, fv;
        upseq[0] = 2'b10; upseq[1] = 2'b11; upseq[2] = 2'b01; upseq[3] = 2'b00;
        // ab en clr | step dir pos err
        add(2'b10, 1, 0, 1, 1, 4'd1, 0);
        add(2'b11, 1, 0, 1, 1, 4'd2, 0);
        add(2'b01, 1, 0, 1, 1, 4'd3, 0);
        add(2'b00, 1, 0, 1, 1, 4'd4, 0);
        add(2'b01, 1, 0, 1, 0, 4'd3, 0);
        add(2'b00, 1, 1, 0, 0, 4'd0, 0);
        add(2'b00, 1, 0, 1, 1, 4'd1, 0);
        add(2'b01, 1, 0, 1, 0, 4'd0, 0);
        add(2'b11, 1, 0, 1, 0, 4'd15, 0);
        add(2'b10, 1, 0, 1, 0, 4'd14, 0);
        add(2'b00, 1, 1, 0, 0, 4'd0, 0);
        for (int i = 0; i < 16; i++)
            add(upseq[(i + 1) % 4], 1, 0, 1, 1, 4'(i + 1), 0);
        add(2'b11, 1, 0, 1, 1, 4'd1, 0);
        add(2'b00, 1, 0, 0, 1, 4'd1, 1);
        add(2'b00, 1, 0, 0, 1, 4'd1, 1);
        add(2'b00, 1, 1, 0, 1, 4'd0, 0);
        add(2'b10, 0, 0, 0, 1, 4'd0, 0);
        add(2'b11, 0, 0, 0, 1, 4'd0, 0);
        add(2'b01, 0, 0, 0, 1, 4'd0, 0);
        add(2'b00, 1, 0, 1, 1, 4'd1, 0);
        add(2'b11, 0, 0, 0, 1, 4'd1, 1);
        add(2'b11, 1, 1, 0, 1, 4'd0, 0);
        add(2'b10, 1, 0, 1, 0, 4'd15, 0);
        add(2'b00, 1, 0, 1, 0, 4'd14, 0);
        add(2'b01, 1, 0, 1, 0, 4'd13, 0);
        add(2'b11, 1, 0, 1, 0, 4'd12, 0);

        rv.ab = 2'b11; rv.en = 1; rv.clr = 0; rv.stp = 0; rv.dr = 1; rv.pos = 4'd0; rv.err = 0;

        repeat (3) @(negedge clk);
        outs("reset", rv);
        reset = 1'b1;
        for (int i = 0; i < S + 4; i++) begin
            @(negedge clk);
            chk($sformatf("init%0d.step", i), 32'(step), 0);
            chk($sformatf("init%0d.err", i), 32'(error), 0);
        end

        foreach (vecs[i]) apply($sformatf("v%0d", i), vecs[i]);

        // transition in flight when reset hits; phases parked at 11 for release
        @(negedge clk);
        phase_a = 1'b0;
        phase_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        phase_a = 1'b1;
        #1;
        sb.push_back(rv);
        outs("midreset", sb.pop_front());
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < S + 5; i++) begin
            @(negedge clk);
            chk($sformatf("rel%0d.step", i), 32'(step), 0);
            chk($sformatf("rel%0d.err", i), 32'(error), 0);
            chk($sformatf("rel%0d.pos", i), 32'(position), 0);
        end
        fv.ab = 2'b01; fv.en = 1; fv.clr = 0; fv.stp = 1; fv.dr = 1; fv.pos = 4'd1; fv.err = 0;
        apply("after_reset", fv);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
